// File: rtl/dtc_cmd_master.sv
// dtc_cmd_master: DTC serial command frames to FEC register bus transactions with serial reply; DTC_MASTER_PARITY_EN adds a trailing even-parity bit
module dtc_cmd_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        dtc_clk,
  input  logic        rst_n,
  input  logic        dtc_din,
  output logic        dtc_dout,
  output logic [31:0] address,
  output logic [31:0] write_data,
  output logic        write,
  output logic        read,
  input  logic [31:0] read_data,
  input  logic        data_vld,
  output logic        busy,
  output logic [7:0]  err_cnt
);
`ifdef DTC_MASTER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  typedef enum logic [2:0] {IDLE, RX_HDR, RX_DATA, RX_PAR, ISSUE, WAIT_VLD, TX} state_t;
  state_t st, nxt;
  logic [7:0] cnt;
  logic [40:0] sr;
  logic [41:0] nsr;
  logic [34:0] tx_sr, tx_load;
  logic rw, rw_n, perr, perr_n, err_inc;
  logic [7:0] addr_f;
  // nsr is the frame including the bit on dtc_din this cycle, so fields can be picked on the last bit
  assign nsr = {sr, dtc_din};
  assign rw_n = st == RX_HDR ? nsr[8] : rw;
  assign addr_f = rw_n ? nsr[39+P -: 8] : nsr[7+P -: 8];
  assign perr_n = (P == 1) && (rw_n ? ^nsr : ^nsr[9:0]);
  assign tx_load = st == ISSUE ? {2'b10, perr, address} : data_vld ? {3'b100, read_data} : {3'b110, 32'h0};
  assign err_inc = (st == ISSUE && perr) || (st == WAIT_VLD && nxt == TX && !data_vld);
  assign busy = st != IDLE;
  assign write = st == ISSUE && rw && !perr;
  assign read = st == ISSUE && !rw && !perr;
  assign dtc_dout = st == TX && tx_sr[34];
  always_comb begin
    nxt = st;
    case (st)
      IDLE:     nxt = dtc_din ? RX_HDR : IDLE;
      RX_HDR:   if (cnt == 8'd8) nxt = nsr[8] ? RX_DATA : (P == 1 ? RX_PAR : ISSUE);
      RX_DATA:  if (cnt == 8'd31) nxt = P == 1 ? RX_PAR : ISSUE;
      RX_PAR:   nxt = ISSUE;
      ISSUE:    nxt = (rw || perr) ? TX : WAIT_VLD;
      WAIT_VLD: if (data_vld || cnt == 8'(TIMEOUT - 1)) nxt = TX;
      TX:       if (cnt == 8'd34) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge dtc_clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      sr <= '0;
      tx_sr <= '0;
      rw <= 1'b0;
      perr <= 1'b0;
      address <= '0;
      write_data <= '0;
      err_cnt <= '0;
    end else begin
      st <= nxt;
      cnt <= nxt != st ? 8'd0 : cnt + 8'd1;
      if (st inside {RX_HDR, RX_DATA, RX_PAR}) sr <= nsr[40:0];
      if (st == RX_HDR) rw <= nsr[8];
      if (nxt == ISSUE) begin
        address <= {24'h0, addr_f};
        perr <= perr_n;
        if (rw_n && !perr_n) write_data <= nsr[31+P -: 32];
      end
      if (nxt == TX && st != TX) tx_sr <= tx_load;
      else if (st == TX) tx_sr <= {tx_sr[33:0], 1'b0};
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_dtc_cmd_master.sv
// tb_dtc_cmd_master: randomized and directed frames against a transaction-level reply model
module tb_dtc_cmd_master;
  localparam int TO = 16;
  logic dtc_clk = 1'b0, rst_n = 1'b0, dtc_din = 1'b0, data_vld = 1'b0;
  logic [31:0] read_data = '0;
  logic dtc_dout, write, read, busy;
  logic [31:0] address, write_data;
  logic [7:0] err_cnt;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m_err = '0;
  logic [31:0] m_wd = '0;
  dtc_cmd_master #(.TIMEOUT(TO)) dut (
    .dtc_clk(dtc_clk), .rst_n(rst_n), .dtc_din(dtc_din), .dtc_dout(dtc_dout),
    .address(address), .write_data(write_data), .write(write), .read(read),
    .read_data(read_data), .data_vld(data_vld), .busy(busy), .err_cnt(err_cnt)
  );
  always #5 dtc_clk = ~dtc_clk;
  task automatic tick;
    @(posedge dtc_clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    dtc_din = b;
    tick;
  endtask
  task automatic run_txn(input bit wr, input logic [7:0] a, input logic [31:0] d, input int dly,
                         input logic [31:0] rdat, input bit junk, input bit bad_par);
    logic [34:0] rep, exp_rep;
    logic [31:0] s_addr, s_wd;
    int nw, nr, t_strobe, t_rep, nbits, exp_t;
    bit done, vld;
    rep = '0; s_addr = 'x; s_wd = 'x;
    nw = 0; nr = 0; t_strobe = -1; t_rep = -1; nbits = 0; done = 0;
    send_bit(1'b1);
    send_bit(wr);
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    if (wr) for (int i = 31; i >= 0; i--) send_bit(d[i]);
`ifdef DTC_MASTER_PARITY_EN
    send_bit(^{wr, a, (wr ? d : 32'h0)} ^ bad_par);
`endif
    for (int c = 0; c < 80 + TO && !done; c++) begin
      if (write) begin nw++; t_strobe = c; s_addr = address; s_wd = write_data; end
      if (read) begin nr++; t_strobe = c; s_addr = address; end
      if (nbits == 35) done = 1;
      else begin
        if (t_rep >= 0 || dtc_dout) begin
          if (t_rep < 0) t_rep = c;
          rep = {rep[33:0], dtc_dout};
          nbits++;
        end
        vld = nr > 0 && c == t_strobe + dly;
        if (!vld && $urandom_range(3) == 0 && (wr || bad_par || (nr > 0 && c > t_strobe + TO))) vld = 1;
        data_vld = vld;
        read_data = (nr > 0 && c == t_strobe + dly) ? rdat : $urandom;
        dtc_din = junk ? 1'($urandom) : 1'b0;
        tick;
      end
    end
    dtc_din = 1'b0;
    data_vld = 1'b0;
    if (wr && !bad_par) m_wd = d;
    if (bad_par || (!wr && dly > TO)) m_err = m_err == 8'hFF ? 8'hFF : m_err + 8'd1;
    exp_rep = bad_par ? {3'b101, 24'h0, a} : wr ? {3'b100, 24'h0, a} :
              dly <= TO ? {3'b100, rdat} : {3'b110, 32'h0};
    exp_t = (wr || bad_par) ? 1 : (dly <= TO ? dly + 1 : TO + 1);
    check("reply_done", done, 1);
    check("write_pulses", nw, (wr && !bad_par) ? 1 : 0);
    check("read_pulses", nr, (!wr && !bad_par) ? 1 : 0);
    check("strobe_cycle", t_strobe, bad_par ? -1 : 0);
    if (!bad_par) check("strobe_address", s_addr, {24'h0, a});
    if (wr && !bad_par) check("strobe_write_data", s_wd, d);
    check("address_hold", address, {24'h0, a});
    check("write_data_hold", write_data, m_wd);
    check("reply_frame", rep, exp_rep);
    check("reply_start", t_rep, exp_t);
    check("err_cnt", err_cnt, m_err);
    check("idle_after", {busy, dtc_dout}, 2'b00);
  endtask
  initial begin
    tick;
    tick;
    check("reset_outputs", {busy, dtc_dout, write, read, address, write_data, err_cnt}, '0);
    rst_n = 1'b1;
    tick;
    run_txn(1, 8'h04, 32'h0000_005A, 0, 32'h0, 0, 0);
    run_txn(0, 8'h20, 32'h0, 1, 32'h0000_1234, 0, 0);
    run_txn(0, 8'h55, 32'h0, 1000, 32'h0, 0, 0);
`ifdef DTC_MASTER_PARITY_EN
    run_txn(1, 8'h3C, 32'hCAFE_F00D, 0, 32'h0, 0, 1);
    run_txn(0, 8'hC3, 32'h0, 2, 32'h0BAD_BEEF, 0, 1);
`endif
    send_bit(1'b1);
    send_bit(1'b1);
    for (int i = 0; i < 18; i++) send_bit(1'($urandom));
    rst_n = 1'b0;
    #1;
    check("reset_mid_frame", {busy, dtc_dout, write, read, address, write_data, err_cnt}, '0);
    m_err = '0;
    m_wd = '0;
    dtc_din = 1'b0;
    tick;
    check("reset_held", {busy, dtc_dout, write, read}, 4'b0);
    rst_n = 1'b1;
    tick;
    run_txn(0, 8'h77, 32'h0, 3, 32'h8765_4321, 0, 0);
    run_txn(1, 8'hFF, 32'hFFFF_FFFF, 0, 32'h0, 1, 0);
    run_txn(0, 8'h00, 32'h0, TO, 32'hA5A5_5A5A, 1, 0);
    run_txn(0, 8'h81, 32'h0, TO + 1, 32'h1111_2222, 1, 0);
    for (int k = 0; k < 40; k++)
      run_txn(1'($urandom), 8'($urandom), $urandom, $urandom_range(1, TO + 3), $urandom,
              1'($urandom), 1'b0);
    for (int k = 0; k < 257; k++)
      run_txn(0, 8'($urandom), 32'h0, 1000, $urandom, k[0], 0);
    check("err_cnt_saturated", err_cnt, 8'hFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
